// File: rtl/inst_queue.sv
// Dual-width instruction queue between decode and issue: up to two pushes and two pops per cycle.
// Head entries and flow control are driven purely from registered state (no decode-to-issue bypass).
module inst_queue #(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned INST_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic [2*INST_W-1:0] dec_inst_i,
   input  logic [1:0]          dec_valid_i,
   output logic                dec_ready_o,
   output logic [2*INST_W-1:0] inst_o,
   output logic [1:0]          d_valid_o,
   input  logic [1:0]          is_i
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [INST_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [PTR_W-1:0] rptr_nxt;
   logic [PTR_W-1:0] wptr_nxt;
   logic             push_en;
   logic [1:0]       push_n;
   logic [1:0]       pop_n;

   // Pointers wrap for free because DEPTH is a power of two.
   assign rptr_nxt = rptr_q + PTR_W'(1);
   assign wptr_nxt = wptr_q + PTR_W'(1);

   // Room for a full pair, judged on the current count only.
   assign dec_ready_o = ((CNT_W'(DEPTH) - count_q) >= CNT_W'(2));

   assign inst_o = {mem_q[rptr_nxt], mem_q[rptr_q]};

   always_comb begin
      d_valid_o = 2'b11;
      if (count_q == CNT_W'(0)) begin
         d_valid_o = 2'b00;
      end else if (count_q == CNT_W'(1)) begin
         d_valid_o = 2'b01;
      end
   end

   // Illegal 2'b10 patterns on valid or grant collapse to zero.
   always_comb begin
      push_en = dec_ready_o & ~flush_i & rst_n;
      push_n  = 2'b00;
      if (push_en) begin
         push_n = {1'b0, dec_valid_i[0]} + {1'b0, dec_valid_i[0] & dec_valid_i[1]};
      end
      pop_n = {1'b0, is_i[0] & d_valid_o[0]}
            + {1'b0, is_i[0] & is_i[1] & d_valid_o[1]};
   end

   always_comb begin
      rptr_d  = rptr_q + PTR_W'(pop_n);
      wptr_d  = wptr_q + PTR_W'(push_n);
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      if (flush_i) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Storage is not reset; d_valid_o masks stale contents.
   always_ff @(posedge clk) begin
      if (push_n != 2'b00) begin
         mem_q[wptr_q] <= dec_inst_i[INST_W-1:0];
      end
      if (push_n == 2'b10) begin
         mem_q[wptr_nxt] <= dec_inst_i[2*INST_W-1:INST_W];
      end
   end

endmodule
